// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Direct-mapped, one-word-per-line cache between a CPU port and a single-port
// RAM. Loads that hit return in one cycle; load misses fetch the word from RAM
// (FILL, FILL_WAIT) and return in three. Stores are write-through and
// write-allocate, returning in two. A flush invalidates every line at once.
// Load hits and load misses are counted in saturating 16-bit counters.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   cpu_req, cpu_we       request strobe (sampled in IDLE only), 1 = store
//   cpu_flush             invalidate all lines (sampled in IDLE only)
//   cpu_addr, cpu_wdata   word address and store data, latched on acceptance
//   cpu_rdata             load data, zero whenever cpu_ready is low
//   cpu_ready, hit        one-cycle completion pulse; hit = load served by cache
//   mem_addr, mem_wdata   RAM address / write data (always the latched values)
//   mem_rdata             RAM read data, valid one cycle after a read access
//   mem_cs, mem_we, mem_oe RAM chip-select, write-enable, output-enable
//   hit_count, miss_count saturating load hit / load miss counters
// -----------------------------------------------------------------------------
module cache_controller #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic                  cpu_flush,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int NUM_LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FILL_WAIT,
        WRITE,
        RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NUM_LINES-1:0]  valid_q;

    logic [DATA_WIDTH-1:0] line_data [NUM_LINES];
    logic [TAG_BITS-1:0]   line_tag  [NUM_LINES];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] lat_index;
    logic [TAG_BITS-1:0]   lat_tag;
    logic                  lookup_hit;
    logic                  line_we;
    logic [DATA_WIDTH-1:0] line_wdata;

    // Lookup uses the live request so a hit can answer in the next cycle.
    assign req_index  = cpu_addr[INDEX_BITS-1:0];
    assign req_tag    = cpu_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign lat_index  = addr_q[INDEX_BITS-1:0];
    assign lat_tag    = addr_q[ADDR_WIDTH-1:INDEX_BITS];
    assign lookup_hit = valid_q[req_index] && (line_tag[req_index] == req_tag);

    // The RAM always sees the latched transaction; only the strobes change.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    // Line update happens on the edge leaving FILL_WAIT or WRITE, so a reset
    // on that edge aborts it.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals; a missing
        // branch would otherwise infer a latch.
        line_we    = 1'b0;
        line_wdata = wdata_q;
        if (!rst) begin
            if (state == FILL_WAIT) begin
                line_we    = 1'b1;
                line_wdata = mem_rdata;
            end else if (state == WRITE) begin
                line_we = 1'b1;
            end
        end
    end

    // NOTE: line data and tags are deliberately not reset; valid_q alone
    // decides whether a line means anything, and a reset loop over the
    // arrays would stop them mapping onto plain RAM.
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_data[lat_index] <= line_wdata;
            line_tag[lat_index]  <= lat_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            cpu_ready  <= 1'b0;
            hit        <= 1'b0;
            cpu_rdata  <= '0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b1;
        end else begin
            // NOTE: non-blocking throughout, so these defaults and the
            // per-state overrides below all act on pre-edge values and the
            // last assignment wins without ordering hazards.
            cpu_ready <= 1'b0;
            hit       <= 1'b0;
            cpu_rdata <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b1;

            case (state)
                IDLE: begin
                    if (cpu_flush) begin
                        // A request arriving with the flush is dropped.
                        valid_q <= '0;
                    end else if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        if (cpu_we) begin
                            state  <= WRITE;
                            mem_cs <= 1'b1;
                            mem_we <= 1'b1;
                            mem_oe <= 1'b0;
                        end else if (lookup_hit) begin
                            state     <= RESP;
                            cpu_ready <= 1'b1;
                            hit       <= 1'b1;
                            cpu_rdata <= line_data[req_index];
                            hit_count <= sat_inc(hit_count);
                        end else begin
                            state  <= FILL;
                            mem_cs <= 1'b1;
                        end
                    end
                end

                // RAM samples the address at the end of FILL.
                FILL: state <= FILL_WAIT;

                // mem_rdata is valid now; answer and count the miss together.
                FILL_WAIT: begin
                    state               <= RESP;
                    valid_q[lat_index]  <= 1'b1;
                    cpu_ready           <= 1'b1;
                    cpu_rdata           <= mem_rdata;
                    miss_count          <= sat_inc(miss_count);
                end

                WRITE: begin
                    state              <= RESP;
                    valid_q[lat_index] <= 1'b1;
                    cpu_ready          <= 1'b1;
                end

                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
//
// Directed bench for cache_controller: reset state, load miss then hit,
// store write-through, conflict eviction, flush with a dropped request,
// reset during a fill, and miss counter saturation. A behavioural RAM with
// one-cycle read latency sits on the memory port.
// -----------------------------------------------------------------------------
module tb_cache_controller;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic          cpu_flush;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;
    logic          hit;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_cs;
    logic          mem_we;
    logic          mem_oe;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    always #5 clk = ~clk;

    cache_controller #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INDEX_BITS(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_flush  (cpu_flush),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .hit        (hit),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_oe     (mem_oe),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // RAM: unwritten words read back a fixed pattern, with RAM[0x10C] = 0x0007.
    bit [DW-1:0] ram     [0:(1<<AW)-1];
    bit          written [0:(1<<AW)-1];

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        if (a == 14'h10C) return 16'h0007;
        return {2'b00, a} ^ 16'hC3C3;
    endfunction

    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_cs && mem_oe)
            mem_rdata <= written[mem_addr] ? ram[mem_addr] : pattern(mem_addr);
    end

    // Bus monitor, sampled mid-cycle.
    int            cs_cycles    = 0;
    int            we_cycles    = 0;
    int            ready_pulses = 0;
    int            rdata_leaks  = 0;
    logic [AW-1:0] cs_addr;
    logic [DW-1:0] cs_wdata;
    logic          cs_oe;

    always @(negedge clk) begin
        if (mem_cs) begin
            cs_cycles <= cs_cycles + 1;
            cs_addr   <= mem_addr;
            cs_wdata  <= mem_wdata;
            cs_oe     <= mem_oe;
            if (mem_we) we_cycles <= we_cycles + 1;
        end
        if (cpu_ready) ready_pulses <= ready_pulses + 1;
        if (!cpu_ready && cpu_rdata != '0) rdata_leaks <= rdata_leaks + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; returns cycles from acceptance to ready.
    // Ends one cycle after the ready pulse, back in IDLE.
    task automatic run_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                           output int lat, output logic [DW-1:0] rd, output logic ht);
        cpu_addr  = a;
        cpu_we    = w;
        cpu_wdata = d;
        cpu_req   = 1'b1;
        tick();
        // Scramble inputs: the controller must use its latched copies.
        cpu_req   = 1'b0;
        cpu_addr  = '1;
        cpu_we    = ~w;
        cpu_wdata = ~d;
        lat = 1;
        while (!cpu_ready && lat < 10) begin
            tick();
            lat++;
        end
        rd = cpu_rdata;
        ht = hit;
        tick();
    endtask

    task automatic load(input string tag, input logic [AW-1:0] a,
                        input int exp_lat, input logic [DW-1:0] exp_rd, input logic exp_hit);
        int            lat;
        logic [DW-1:0] rd;
        logic          ht;
        run_req(a, 1'b0, '0, lat, rd, ht);
        check({tag, "_lat"},   lat, exp_lat);
        check({tag, "_rdata"}, rd,  exp_rd);
        check({tag, "_hit"},   ht,  exp_hit);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int            cs0;
        int            we0;
        int            rp0;
        int            lat;
        logic [DW-1:0] rd;
        logic          ht;

        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_flush = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        do_reset();

        // Reset state
        check("rst_ready", cpu_ready, 1'b0);
        check("rst_hit", hit, 1'b0);
        check("rst_rdata", cpu_rdata, 16'h0);
        check("rst_cs", mem_cs, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_oe", mem_oe, 1'b1);
        check("rst_maddr", mem_addr, 14'h0);
        check("rst_mwdata", mem_wdata, 16'h0);
        check("rst_hitcnt", hit_count, 16'h0);
        check("rst_misscnt", miss_count, 16'h0);

        // Load miss then hit
        cs0 = cs_cycles;
        load("miss10C", 14'h10C, 3, 16'h0007, 1'b0);
        check("miss10C_cnt", miss_count, 16'd1);
        check("miss10C_cs", cs_cycles - cs0, 1);
        check("miss10C_csaddr", cs_addr, 14'h10C);
        check("miss10C_csoe", cs_oe, 1'b1);
        cs0 = cs_cycles;
        load("hit10C", 14'h10C, 1, 16'h0007, 1'b1);
        check("hit10C_cnt", hit_count, 16'd1);
        check("hit10C_nocs", cs_cycles - cs0, 0);

        // Store write-through, then load hit
        cs0 = cs_cycles;
        we0 = we_cycles;
        run_req(14'h10D, 1'b1, 16'h0023, lat, rd, ht);
        check("st10D_lat", lat, 2);
        check("st10D_hit", ht, 1'b0);
        check("st10D_cs", cs_cycles - cs0, 1);
        check("st10D_we", we_cycles - we0, 1);
        check("st10D_addr", cs_addr, 14'h10D);
        check("st10D_wdata", cs_wdata, 16'h0023);
        check("st10D_oe", cs_oe, 1'b0);
        check("st10D_hitcnt", hit_count, 16'd1);
        check("st10D_misscnt", miss_count, 16'd1);
        load("ld10D", 14'h10D, 1, 16'h0023, 1'b1);
        check("ld10D_cnt", hit_count, 16'd2);

        // Conflict eviction on index 0xC
        do_reset();
        load("ev10C", 14'h10C, 3, 16'h0007, 1'b0);
        load("ev11C", 14'h11C, 3, 16'hC2DF, 1'b0);
        load("ev10C_again", 14'h10C, 3, 16'h0007, 1'b0);
        check("ev_misscnt", miss_count, 16'd3);

        // Flush drops a simultaneous request
        load("fl10B_miss", 14'h10B, 3, 16'hC2C8, 1'b0);
        load("fl10B_hit1", 14'h10B, 1, 16'hC2C8, 1'b1);
        load("fl10B_hit2", 14'h10B, 1, 16'hC2C8, 1'b1);
        rp0 = ready_pulses;
        cs0 = cs_cycles;
        cpu_addr  = 14'h10B;
        cpu_we    = 1'b0;
        cpu_req   = 1'b1;
        cpu_flush = 1'b1;
        tick();
        cpu_req   = 1'b0;
        cpu_flush = 1'b0;
        repeat (5) tick();
        check("fl_noready", ready_pulses - rp0, 0);
        check("fl_nocs", cs_cycles - cs0, 0);
        load("fl10B_after", 14'h10B, 3, 16'hC2C8, 1'b0);
        check("fl_hitcnt", hit_count, 16'd2);
        check("fl_misscnt", miss_count, 16'd5);

        // Reset during FILL_WAIT aborts the miss
        rp0 = ready_pulses;
        cpu_addr = 14'h10C;
        cpu_we   = 1'b0;
        cpu_req  = 1'b1;
        tick();
        cpu_req = 1'b0;
        check("rm_fill_cs", mem_cs, 1'b1);
        check("rm_fill_oe", mem_oe, 1'b1);
        check("rm_fill_addr", mem_addr, 14'h10C);
        tick();
        check("rm_wait_cs", mem_cs, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("rm_noready", ready_pulses - rp0, 0);
        check("rm_hitcnt", hit_count, 16'd0);
        check("rm_misscnt", miss_count, 16'd0);
        load("rm_reload", 14'h10C, 3, 16'h0007, 1'b0);
        check("rm_reload_cnt", miss_count, 16'd1);

        // Miss counter saturation: alternate two tags on index 0
        do_reset();
        for (int i = 0; i < 16'hFFFE; i++)
            run_req((i % 2 == 1) ? 14'h010 : 14'h000, 1'b0, '0, lat, rd, ht);
        check("sat_fffe", miss_count, 16'hFFFE);
        check("sat_hitcnt", hit_count, 16'd0);
        load("sat_m1", 14'h000, 3, 16'hC3C3, 1'b0);
        check("sat_ffff_1", miss_count, 16'hFFFF);
        load("sat_m2", 14'h010, 3, 16'hC3D3, 1'b0);
        check("sat_ffff_2", miss_count, 16'hFFFF);

        check("rdata_zero_when_idle", rdata_leaks, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
